// File: rtl/int_seq.sv
// rtl/int_seq.sv - prioritised interrupt entry/return sequencer
// Optional feature macro: INT_SEQ_NESTING_EN (enables preemptive nesting up to NEST_DEPTH).
module int_seq #(
  parameter int          N_SRC      = 8,
  parameter int          PC_W       = 32,
  parameter int unsigned VEC_BASE   = 32'h10,
  parameter int unsigned VEC_STRIDE = 4,
  parameter int          NEST_DEPTH = 4,
  localparam int         LVL_W      = (N_SRC > 1) ? $clog2(N_SRC) : 1,
  localparam int         DEP_W      = $clog2(NEST_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq,
  input  logic [N_SRC-1:0] mask,
  input  logic             cpu_ready,
  input  logic             ret_req,
  output logic             sp_push,
  output logic             sp_pop,
  output logic             stk_sel,
  output logic             write_pc,
  output logic [1:0]       pc_s,
  output logic             write_cpsr,
  output logic [PC_W-1:0]  vector,
  output logic [N_SRC-1:0] ack,
  output logic             active,
  output logic [LVL_W-1:0] level,
  output logic [DEP_W-1:0] depth,
  output logic             spurious_ret,
  output logic [2:0]       st
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENT_PC  = 3'd1,
    S_ENT_PSR = 3'd2,
    S_ENT_VEC = 3'd3,
    S_RUN     = 3'd4,
    S_RET_PSR = 3'd5,
    S_RET_PC  = 3'd6
  } state_t;

  state_t           state;
  logic [N_SRC-1:0] pending;
  logic             cand_ok;
  logic [LVL_W-1:0] cand_idx;
  logic [LVL_W-1:0] idx_q;
  logic             take;
  logic [LVL_W-1:0] pop_lvl;

  assign st      = state;
  assign pending = irq & ~mask;

  // Lowest pending index wins (bit 0 is the highest priority).
  always_comb begin
    cand_ok  = 1'b0;
    cand_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (pending[i]) begin
        cand_ok  = 1'b1;
        cand_idx = LVL_W'(i);
      end
    end
  end

`ifdef INT_SEQ_NESTING_EN
  localparam int SP_W = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;

  logic [LVL_W-1:0] lvl_stk [2**SP_W];
  logic [SP_W-1:0]  push_ptr;
  logic [SP_W-1:0]  pop_ptr;

  assign push_ptr = SP_W'(depth);
  assign pop_ptr  = SP_W'(depth - DEP_W'(1));
  assign pop_lvl  = lvl_stk[pop_ptr];
  // Preempt only a strictly lower-priority handler, and only while stack room remains.
  assign take     = cand_ok && (depth < DEP_W'(NEST_DEPTH)) &&
                    ((depth == '0) || (cand_idx < level));

  // Save the interrupted level as the entry commits (ENT_PSR -> ENT_VEC).
  always_ff @(posedge clk) begin
    if (state == S_ENT_PSR) lvl_stk[push_ptr] <= level;
  end
`else
  assign pop_lvl = '0;
  // Without nesting a single handler runs at a time.
  assign take    = cand_ok && (depth == '0);
`endif

  // Sequencer: every output is registered with the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      idx_q        <= '0;
      sp_push      <= 1'b0;
      sp_pop       <= 1'b0;
      stk_sel      <= 1'b0;
      write_pc     <= 1'b0;
      pc_s         <= 2'b00;
      write_cpsr   <= 1'b0;
      vector       <= '0;
      ack          <= '0;
      active       <= 1'b0;
      level        <= '0;
      depth        <= '0;
      spurious_ret <= 1'b0;
    end else begin
      sp_push      <= 1'b0;
      sp_pop       <= 1'b0;
      stk_sel      <= 1'b0;
      write_pc     <= 1'b0;
      pc_s         <= 2'b00;
      write_cpsr   <= 1'b0;
      ack          <= '0;
      spurious_ret <= 1'b0;
      case (state)
        S_IDLE, S_RUN: begin
          if (cpu_ready) begin
            if (ret_req && (depth != '0)) begin
              state      <= S_RET_PSR;
              sp_pop     <= 1'b1;
              stk_sel    <= 1'b1;
              write_cpsr <= 1'b1;
            end else if (ret_req) begin
              spurious_ret <= 1'b1;
            end else if (take) begin
              state   <= S_ENT_PC;
              idx_q   <= cand_idx;
              sp_push <= 1'b1;
            end
          end
        end
        S_ENT_PC: begin
          state   <= S_ENT_PSR;
          sp_push <= 1'b1;
          stk_sel <= 1'b1;
        end
        S_ENT_PSR: begin
          state    <= S_ENT_VEC;
          write_pc <= 1'b1;
          pc_s     <= 2'b01;
          ack      <= N_SRC'(1) << idx_q;
          vector   <= PC_W'(VEC_BASE) + PC_W'(idx_q) * PC_W'(VEC_STRIDE);
          level    <= idx_q;
          depth    <= depth + DEP_W'(1);
          active   <= 1'b1;
        end
        S_ENT_VEC: begin
          state <= S_RUN;
        end
        S_RET_PSR: begin
          state    <= S_RET_PC;
          sp_pop   <= 1'b1;
          write_pc <= 1'b1;
          pc_s     <= 2'b10;
          depth    <= depth - DEP_W'(1);
          active   <= (depth != DEP_W'(1));
          level    <= pop_lvl;
        end
        S_RET_PC: begin
          state <= (depth != '0) ? S_RUN : S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
